jzj_regfile_scoreboard: RTL and testbench
=========================================

// Module: jzj_regfile_scoreboard
// PURPOSE
//  Parametrised integer register file with per-register busy scoreboard for the pipelined core.
//  Takes rs/rd addresses from the instruction decoder; returns registered operands plus hazard (busy) flags.
//  Accepts writeback from MEMORY/ALU/IMMEDIATE_FORMER/BRANCH_ALU paths.
//  Generalises the fixed 2-read/1-write 32x32 file to N read ports and any register count/width.
// PARAMETERS
//  XLEN            32   register width in bits
//  NUM_REGS        32   number of architectural registers, power of two, >=2
//  NUM_READ_PORTS  2    independent read ports
//  ADDR_W          $clog2(NUM_REGS)  address width (derived, not overridden)
// PORTS
//  clock          in   1                     rising-edge clock
//  reset          in   1                     async, active-high
//  rs_addr        in   NUM_READ_PORTS*ADDR_W read addresses, port i at [i*ADDR_W +: ADDR_W]
//  rs_data        out  NUM_READ_PORTS*XLEN   registered read data, port i at [i*XLEN +: XLEN]
//  rs_busy        out  NUM_READ_PORTS        registered busy flag for each read address
//  issue_valid    in   1                     decoder issuing instr that will write issue_rd
//  issue_rd       in   ADDR_W                destination of issuing instr
//  issue_ready    out  1                     combinational; issue accepted when valid&&ready
//  wb_valid       in   1                     writeback strobe
//  wb_rd          in   ADDR_W                writeback destination
//  wb_data        in   XLEN                  writeback value
//  flush          in   1                     pipeline flush: clear all busy bits
//  wb_error       out  1                     sticky: writeback to a non-busy, nonzero register
// BEHAVIOUR
//  Reset (async): all registers = 0, all busy = 0, rs_data = 0, rs_busy = 0, wb_error = 0.
//  Register 0 is hardwired:
//   - reads return 0 and busy 0;
//   - writes are discarded;
//   - issue to rd 0 is always ready and never sets busy.
//  Read latency is 1 cycle:
//   - rs_data/rs_busy sampled at edge N reflect rs_addr presented in cycle N-1.
//   - Same-cycle writeback bypass: when wb_valid && wb_rd==rs_addr[i] (nonzero), rs_data[i] takes
//     wb_data, not the stale array value.
//   - rs_busy[i] reflects the post-update busy state for that edge.
//  Write: on edge with wb_valid && wb_rd!=0, reg[wb_rd] <= wb_data; busy[wb_rd] <= 0
//   unless overridden by a same-edge issue (below).
//  issue_ready = !flush && (issue_rd==0 || !busy[issue_rd] || (wb_valid && wb_rd==issue_rd)).
//   - WAW on an outstanding destination stalls the decoder.
//  Issue: on edge with issue_valid && issue_ready && issue_rd!=0, busy[issue_rd] <= 1.
//  Simultaneous wb and issue to the same rd: data is written AND busy ends 1 (issue wins).
//  Simultaneous wb and issue to different rds: both take effect.
//  flush:
//   - all busy <= 0 on that edge;
//   - issue ignored (issue_ready=0);
//   - wb data still written;
//   - rs_busy for that edge reports 0.
//  wb_error is set when wb_valid && wb_rd!=0 && !busy[wb_rd] && !flush. Cleared only by reset.
//   The write still takes effect.
//  issue_valid with issue_ready=0 has no state effect; the decoder holds the request.
//  Reset mid-operation: all state clears immediately; pending busy bits are lost by design.
//  Address width: rs_addr/issue_rd/wb_rd use ADDR_W bits only; no out-of-range addresses exist.
// TESTING
//  1. Reset then read all regs on every port -> rs_data=0, rs_busy=0, wb_error=0.
//  2. wb x5=0xDEADBEEF with rs_addr[0]=5 in the same cycle -> next edge rs_data[0]=0xDEADBEEF (bypass).
//  3. Issue rd=7 -> busy; second issue rd=7 -> issue_ready=0 until wb x7=0x11;
//     issue rd=7 with that wb -> x7=0x11, busy=1.
//  4. wb x0=0xFFFFFFFF, issue rd=0 -> x0 reads 0, never busy, no wb_error.
//  5. Issue rd=3 and rd=9, then flush -> both busy clear; a same-cycle issue of rd=4 is
//     ignored; a later wb x4 sets wb_error.
//  6. NUM_READ_PORTS=3, NUM_REGS=64, XLEN=64: write x63=0x0123456789ABCDEF; read 63,0,63
//     -> port data 0x0123456789ABCDEF, 0, 0x0123456789ABCDEF.

Source files
------------

// File: rtl/jzj_regfile_scoreboard.sv
// jzj_regfile_scoreboard
// Integer register file with a per-register busy scoreboard for the pipelined core.
// Reads have one cycle of latency and bypass a same-cycle writeback. Issue marks a
// destination busy and writeback clears it. Flush drops every busy bit. x0 is hardwired to zero.

module jzj_regfile_scoreboard #(
  parameter int XLEN           = 32,
  parameter int NUM_REGS       = 32,
  parameter int NUM_READ_PORTS = 2,
  localparam int ADDR_W        = $clog2(NUM_REGS)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_READ_PORTS*ADDR_W-1:0] rs_addr,
  output logic [NUM_READ_PORTS*XLEN-1:0]   rs_data,
  output logic [NUM_READ_PORTS-1:0]        rs_busy,
  input  logic                             issue_valid,
  input  logic [ADDR_W-1:0]                issue_rd,
  output logic                             issue_ready,
  input  logic                             wb_valid,
  input  logic [ADDR_W-1:0]                wb_rd,
  input  logic [XLEN-1:0]                  wb_data,
  input  logic                             flush,
  output logic                             wb_error
);

  logic [XLEN-1:0]                 regs_q [NUM_REGS];
  logic [XLEN-1:0]                 regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]             busy_q;
  logic [NUM_REGS-1:0]             busy_d;
  logic [NUM_READ_PORTS*XLEN-1:0]  rs_data_q;
  logic [NUM_READ_PORTS*XLEN-1:0]  rs_data_d;
  logic [NUM_READ_PORTS-1:0]       rs_busy_q;
  logic [NUM_READ_PORTS-1:0]       rs_busy_d;
  logic                            wb_error_q;
  logic                            wb_error_d;

  logic                            wb_fire_s;
  logic                            issue_ready_s;
  logic                            issue_fire_s;
  logic [ADDR_W-1:0]               rd_addr_s [NUM_READ_PORTS];

  // Writeback and issue qualifiers; x0 never takes part in either.
  always_comb begin
    wb_fire_s     = wb_valid && (wb_rd != '0);
    issue_ready_s = !flush && ((issue_rd == '0) || !busy_q[issue_rd] ||
                               (wb_valid && (wb_rd == issue_rd)));
    issue_fire_s  = issue_valid && issue_ready_s && (issue_rd != '0);
  end

  // Split the packed read-address bus into per-port addresses.
  always_comb begin
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      rd_addr_s[i] = rs_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Register array update: writeback data lands even during a flush.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    if (wb_fire_s) begin
      regs_d[wb_rd] = wb_data;
    end else begin
      regs_d[wb_rd] = regs_q[wb_rd];
    end
    regs_d[0] = '0;
  end

  // Scoreboard update: writeback clears, a same-edge issue re-sets, flush clears all.
  always_comb begin
    busy_d = busy_q;
    if (wb_fire_s) begin
      busy_d[wb_rd] = 1'b0;
    end else begin
      busy_d[wb_rd] = busy_q[wb_rd];
    end
    if (issue_fire_s) begin
      busy_d[issue_rd] = 1'b1;
    end else begin
      busy_d[issue_rd] = busy_d[issue_rd];
    end
    if (flush) begin
      busy_d = '0;
    end else begin
      busy_d[0] = 1'b0;
    end
  end

  // Read ports: bypass a same-cycle writeback and report post-update busy state.
  always_comb begin
    rs_data_d = '0;
    rs_busy_d = '0;
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      if (rd_addr_s[i] == '0) begin
        rs_data_d[i*XLEN +: XLEN] = '0;
        rs_busy_d[i]              = 1'b0;
      end else if (wb_fire_s && (wb_rd == rd_addr_s[i])) begin
        rs_data_d[i*XLEN +: XLEN] = wb_data;
        rs_busy_d[i]              = busy_d[rd_addr_s[i]];
      end else begin
        rs_data_d[i*XLEN +: XLEN] = regs_q[rd_addr_s[i]];
        rs_busy_d[i]              = busy_d[rd_addr_s[i]];
      end
    end
  end

  // Sticky error: a writeback arrived for a register nobody had issued to.
  always_comb begin
    if (wb_fire_s && !busy_q[wb_rd] && !flush) begin
      wb_error_d = 1'b1;
    end else begin
      wb_error_d = wb_error_q;
    end
  end

  // State register: every flop clears immediately on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q     <= '0;
      rs_data_q  <= '0;
      rs_busy_q  <= '0;
      wb_error_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q     <= busy_d;
      rs_data_q  <= rs_data_d;
      rs_busy_q  <= rs_busy_d;
      wb_error_q <= wb_error_d;
    end
  end

  assign rs_data     = rs_data_q;
  assign rs_busy     = rs_busy_q;
  assign wb_error    = wb_error_q;
  assign issue_ready = issue_ready_s;

endmodule

// File: tb/tb_jzj_regfile_scoreboard.sv
// Self-checking bench for jzj_regfile_scoreboard: directed scenarios plus randomized
// traffic against a per-cycle reference model of the architectural rules.

module tb_jzj_regfile_scoreboard;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  // Default configuration: 32 x 32, two read ports.
  logic [9:0]  rs_addr = '0;
  logic [63:0] rs_data;
  logic [1:0]  rs_busy;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        issue_ready;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        wb_error;

  // Wide configuration: 64 x 64, three read ports.
  logic [17:0]  b_rs_addr = '0;
  logic [191:0] b_rs_data;
  logic [2:0]   b_rs_busy;
  logic         b_issue_valid = 1'b0;
  logic [5:0]   b_issue_rd = '0;
  logic         b_issue_ready;
  logic         b_wb_valid = 1'b0;
  logic [5:0]   b_wb_rd = '0;
  logic [63:0]  b_wb_data = '0;
  logic         b_flush = 1'b0;
  logic         b_wb_error;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  logic        m_busy [32];
  logic        m_err;

  jzj_regfile_scoreboard dut (
    .clock(clock), .reset(reset), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .wb_error(wb_error)
  );

  jzj_regfile_scoreboard #(.XLEN(64), .NUM_REGS(64), .NUM_READ_PORTS(3)) dut_wide (
    .clock(clock), .reset(reset), .rs_addr(b_rs_addr), .rs_data(b_rs_data), .rs_busy(b_rs_busy),
    .issue_valid(b_issue_valid), .issue_rd(b_issue_rd), .issue_ready(b_issue_ready),
    .wb_valid(b_wb_valid), .wb_rd(b_wb_rd), .wb_data(b_wb_data), .flush(b_flush),
    .wb_error(b_wb_error)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  // Asynchronous reset pulse; outputs must clear without waiting for an edge.
  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    #1;
    check_val("reset_rs_data", rs_data, 64'd0);
    check_val("reset_rs_busy", 64'(rs_busy), 64'd0);
    check_val("reset_wb_error", 64'(wb_error), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // One clock of traffic: drive, check issue_ready, advance model, check registered outputs.
  task automatic step(input logic [4:0] a0, input logic [4:0] a1,
                      input logic iv, input logic [4:0] ird,
                      input logic wbv, input logic [4:0] wrd, input logic [31:0] wd,
                      input logic fl);
    logic exp_ready;
    rs_addr     = {a1, a0};
    issue_valid = iv;
    issue_rd    = ird;
    wb_valid    = wbv;
    wb_rd       = wrd;
    wb_data     = wd;
    flush       = fl;
    #1;
    exp_ready = !fl && (ird == 5'd0 || !m_busy[ird] || (wbv && wrd == ird));
    check_val("issue_ready", 64'(issue_ready), 64'(exp_ready));
    if (wbv && wrd != 5'd0 && !m_busy[wrd] && !fl) m_err = 1'b1;
    if (wbv && wrd != 5'd0) begin
      m_regs[wrd] = wd;
      m_busy[wrd] = 1'b0;
    end
    if (iv && exp_ready && ird != 5'd0) m_busy[ird] = 1'b1;
    if (fl) begin
      for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    end
    @(posedge clock);
    #1;
    check_val("rs_data0", 64'(rs_data[31:0]),  64'((a0 == 5'd0) ? 32'd0 : m_regs[a0]));
    check_val("rs_data1", 64'(rs_data[63:32]), 64'((a1 == 5'd0) ? 32'd0 : m_regs[a1]));
    check_val("rs_busy0", 64'(rs_busy[0]), 64'((a0 == 5'd0) ? 1'b0 : m_busy[a0]));
    check_val("rs_busy1", 64'(rs_busy[1]), 64'((a1 == 5'd0) ? 1'b0 : m_busy[a1]));
    check_val("wb_error", 64'(wb_error), 64'(m_err));
  endtask

  initial begin
    logic [4:0]  ra0, ra1, rird, rwrd;
    logic        riv, rwbv, rfl;
    logic [31:0] rwd;

    model_clear();
    @(posedge clock);
    #1;
    do_reset();

    // Every register reads zero and idle after reset
    for (int r = 0; r < 32; r += 2) begin
      step(5'(r), 5'(r + 1), 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    end

    // Writeback bypass onto a read in the same cycle
    step(5'd0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0);
    step(5'd5, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    check_val("t2_bypass", 64'(rs_data[31:0]), 64'h0000_0000_DEAD_BEEF);

    // WAW stall on x7, released by writeback with issue winning the busy bit
    step(5'd0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0);
    step(5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0);
    check_val("t3_busy7", 64'(rs_busy[0]), 64'd1);
    step(5'd7, 5'd0, 1'b1, 5'd7, 1'b1, 5'd7, 32'h11, 1'b0);
    check_val("t3_data7", 64'(rs_data[31:0]), 64'h11);
    check_val("t3_still_busy7", 64'(rs_busy[0]), 64'd1);

    // x0 stays zero, never busy, and raises no error
    step(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    check_val("t4_x0_data", rs_data, 64'd0);
    check_val("t4_x0_err", 64'(wb_error), 64'd0);
    step(5'd7, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h22, 1'b0);

    // Flush clears busy bits and blocks a same-cycle issue
    step(5'd0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0);
    step(5'd3, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0);
    step(5'd3, 5'd9, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0, 1'b1);
    check_val("t5_flush_busy", 64'(rs_busy), 64'd0);
    step(5'd4, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 32'h44, 1'b0);
    check_val("t5_wb_error", 64'(wb_error), 64'd1);

    // Mid-operation reset, then randomized traffic with occasional resets
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(99, 0) == 0) begin
        do_reset();
      end
      rird = 5'($urandom_range(31, 0));
      rwrd = 5'($urandom_range(31, 0));
      if ($urandom_range(3, 0) != 0) begin
        for (int t = 0; t < 8; t++) begin
          if (!m_busy[rwrd]) rwrd = 5'($urandom_range(31, 0));
        end
      end
      ra0  = ($urandom_range(3, 0) == 0) ? rwrd : 5'($urandom_range(31, 0));
      ra1  = ($urandom_range(3, 0) == 0) ? rird : 5'($urandom_range(31, 0));
      riv  = 1'($urandom_range(1, 0));
      rwbv = 1'($urandom_range(1, 0));
      rfl  = ($urandom_range(19, 0) == 0);
      rwd  = $urandom;
      if ($urandom_range(7, 0) == 0) rird = rwrd;
      step(ra0, ra1, riv, rird, rwbv, rwrd, rwd, rfl);
    end
    step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);

    // Wide configuration: write x63 and read 63, 0, 63 (bypass, then stored value)
    b_rs_addr  = {6'd63, 6'd0, 6'd63};
    b_wb_valid = 1'b1;
    b_wb_rd    = 6'd63;
    b_wb_data  = 64'h0123456789ABCDEF;
    @(posedge clock);
    #1;
    b_wb_valid = 1'b0;
    check_val("wide_byp_p0", b_rs_data[63:0],    64'h0123456789ABCDEF);
    check_val("wide_byp_p1", b_rs_data[127:64],  64'd0);
    check_val("wide_byp_p2", b_rs_data[191:128], 64'h0123456789ABCDEF);
    @(posedge clock);
    #1;
    check_val("wide_p0", b_rs_data[63:0],    64'h0123456789ABCDEF);
    check_val("wide_p1", b_rs_data[127:64],  64'd0);
    check_val("wide_p2", b_rs_data[191:128], 64'h0123456789ABCDEF);
    check_val("wide_busy", 64'(b_rs_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
